// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA fetch > posted-write drain > CPU direct access.
// Define VRAM_WBUF_EN to post CPU writes through a WBUF_DEPTH-entry FIFO.
module vram_arbiter #(
   parameter int AW           = 19,
   parameter int DW           = 12,
   parameter int WBUF_DEPTH   = 4,
   parameter int STARVE_LIMIT = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          vga_req,
   input  logic [AW-1:0] vga_addr,
   output logic          vga_valid,
   output logic [DW-1:0] vga_data,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_starve,
   output logic          vram_en,
   output logic          vram_we,
   output logic [AW-1:0] vram_addr,
   output logic [DW-1:0] vram_din,
   input  logic [DW-1:0] vram_dout
);

   typedef enum logic [1:0] {IDLE, RD_WAIT, ACK} state_t;

   state_t        state, state_nx;
   logic [7:0]    wait_cnt;
   logic          cpu_go;
   logic          wb_push, wb_pop, wb_empty, wb_full;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;

`ifdef VRAM_WBUF_EN
   localparam bit WBUF = 1'b1;
   // Depth must be a power of 2 and at least 2 so the pointers wrap cleanly.
   localparam int PW   = $clog2(WBUF_DEPTH);

   logic [AW+DW-1:0] wb_mem [WBUF_DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [PW:0]      wb_cnt;

   assign wb_empty           = (wb_cnt == '0);
   assign wb_full            = (wb_cnt == (PW+1)'(WBUF_DEPTH));
   assign {wb_addr, wb_data} = wb_mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         wb_cnt <= '0;
      end else begin
         if (wb_push) wr_ptr <= wr_ptr + PW'(1);
         if (wb_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({wb_push, wb_pop})
            2'b10:   wb_cnt <= wb_cnt + (PW+1)'(1);
            2'b01:   wb_cnt <= wb_cnt - (PW+1)'(1);
            default: wb_cnt <= wb_cnt;
         endcase
      end
   end

   // Storage needs no reset: only entries counted in wb_cnt are ever read.
   always_ff @(posedge clk) begin
      if (wb_push) wb_mem[wr_ptr] <= {cpu_addr, cpu_wdata};
   end
`else
   localparam bit WBUF = 1'b0;

   assign wb_empty = 1'b1;
   assign wb_full  = 1'b0;
   assign wb_addr  = '0;
   assign wb_data  = '0;

   logic unused_wb;
   assign unused_wb = wb_push | wb_pop;
`endif

   // Port grant is combinational; everything is held off while reset is low.
   always_comb begin
      vram_en   = 1'b0;
      vram_we   = 1'b0;
      vram_addr = '0;
      vram_din  = '0;
      wb_push   = 1'b0;
      wb_pop    = 1'b0;
      cpu_go    = 1'b0;
      state_nx  = state;
      if (rst) begin
         if (vga_req) begin
            vram_en   = 1'b1;
            vram_addr = vga_addr;
         end else if (!wb_empty) begin
            vram_en   = 1'b1;
            vram_we   = 1'b1;
            vram_addr = wb_addr;
            vram_din  = wb_data;
            wb_pop    = 1'b1;
         end else if (state == IDLE && cpu_req && !(WBUF && cpu_we)) begin
            vram_en   = 1'b1;
            vram_we   = cpu_we;
            vram_addr = cpu_addr;
            vram_din  = cpu_wdata;
            cpu_go    = 1'b1;
         end
         // Posted writes bypass the port entirely, so VGA traffic cannot block them.
         if (state == IDLE && cpu_req && WBUF && cpu_we && !wb_full) begin
            wb_push = 1'b1;
            cpu_go  = 1'b1;
         end
      end
      case (state)
         IDLE:    if (cpu_go) state_nx = cpu_we ? ACK : RD_WAIT;
         RD_WAIT: state_nx = ACK;
         ACK:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         cpu_rdata <= '0;
         vga_valid <= 1'b0;
      end else begin
         state     <= state_nx;
         vga_valid <= vga_req;
         if (state == RD_WAIT) cpu_rdata <= vram_dout;
         if (state == ACK)
            wait_cnt <= '0;
         else if (state == IDLE && cpu_req && !cpu_go && wait_cnt != 8'hFF)
            wait_cnt <= wait_cnt + 8'd1;
      end
   end

   assign cpu_ack    = (state == ACK);
   assign vga_data   = vga_valid ? vram_dout : '0;
   assign cpu_starve = (int'(wait_cnt) >= STARVE_LIMIT);

endmodule
